// File: rtl/sd_pkg.sv
// Shared constants and FSM encoding for the SD sector client.
package sd_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned NUM_DRIVES   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StFinish
  } sd_state_e;

endpackage

// File: rtl/sd_sector_buf.sv
// One-sector 512x8 true dual-port buffer with registered reads on both ports.
module sd_sector_buf (
  input  logic       clk,
  input  logic [8:0] a_addr,
  input  logic [7:0] a_din,
  input  logic       a_we,
  output logic [7:0] a_dout,
  input  logic [8:0] b_addr,
  input  logic [7:0] b_din,
  input  logic       b_we,
  output logic [7:0] b_dout
);
  import sd_pkg::*;

  logic [7:0] mem [SECTOR_BYTES];

  // Reads return pre-write data; port b is written last so it wins a same-address clash.
  always_ff @(posedge clk) begin
    a_dout <= mem[a_addr];
    b_dout <= mem[b_addr];
    if (a_we) mem[a_addr] <= a_din;
    if (b_we) mem[b_addr] <= b_din;
  end

endmodule

// File: rtl/sd_sector_client.sv
// Single-request sector read/write client between a user buffer and an SD responder.
module sd_sector_client #(
  parameter int unsigned TIMEOUT_CYC = 16777215
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_lba,
  input  logic        req_drive,
  output logic        req_ready,
  output logic        done,
  output logic        error,
  input  logic [1:0]  image_mounted,
  input  logic [8:0]  buf_addr,
  input  logic [7:0]  buf_din,
  input  logic        buf_we,
  output logic [7:0]  buf_dout,
  output logic [1:0]  rstart,
  output logic [1:0]  wstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  output logic [7:0]  inbyte
);
  import sd_pkg::*;

  localparam logic [9:0]  FULL_CNT = 10'(SECTOR_BYTES);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  sd_state_e   state_q;
  logic [31:0] lba_q;
  logic        drive_q;
  logic        is_rd_q;
  logic [1:0]  rstart_q;
  logic [1:0]  wstart_q;
  logic [31:0] rsector_q;
  logic        done_q;
  logic        error_q;
  logic [9:0]  bcnt_q;
  logic [31:0] tcnt_q;
  logic        sd_we;
  logic        unused_rbusy;

  assign unused_rbusy = rbusy;
  assign sd_we        = outen && is_rd_q && (state_q == StWait);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      lba_q     <= '0;
      drive_q   <= 1'b0;
      is_rd_q   <= 1'b0;
      rstart_q  <= '0;
      wstart_q  <= '0;
      rsector_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      bcnt_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Read takes priority when both pulses arrive together.
          if (req_rd || req_wr) begin
            lba_q   <= req_lba;
            drive_q <= req_drive;
            is_rd_q <= req_rd;
            if (image_mounted[req_drive]) begin
              error_q <= 1'b0;
              state_q <= StStart;
            end else begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= StFinish;
            end
          end
        end
        StStart: begin
          rsector_q <= lba_q;
          bcnt_q    <= '0;
          tcnt_q    <= '0;
          if (is_rd_q) rstart_q[drive_q] <= 1'b1;
          else         wstart_q[drive_q] <= 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          if (sd_we) bcnt_q <= bcnt_q + 10'd1;
          tcnt_q <= tcnt_q + 32'd1;
          if (rdone || (tcnt_q == TMO_LAST)) begin
            rstart_q <= '0;
            wstart_q <= '0;
            done_q   <= 1'b1;
            error_q  <= rdone ? (is_rd_q && (bcnt_q != FULL_CNT)) : 1'b1;
            state_q  <= StFinish;
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = (state_q == StIdle);
  assign done      = done_q;
  assign error     = error_q;
  assign rstart    = rstart_q;
  assign wstart    = wstart_q;
  assign rsector   = rsector_q;

  sd_sector_buf u_buf (
    .clk    (clk),
    .a_addr (buf_addr),
    .a_din  (buf_din),
    .a_we   (buf_we),
    .a_dout (buf_dout),
    .b_addr (outaddr),
    .b_din  (outbyte),
    .b_we   (sd_we),
    .b_dout (inbyte)
  );

endmodule

// File: tb/tb_sd_sector_client.sv
// Randomized bench for sd_sector_client against a transaction-level model and buffer image.
module tb_sd_sector_client;

  localparam int unsigned T_MAIN  = 600;
  localparam int unsigned T_SHORT = 100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_rd, req_wr, req_drive;
  logic [31:0] req_lba;
  logic [1:0]  image_mounted;
  logic [8:0]  buf_addr, outaddr;
  logic [7:0]  buf_din, outbyte;
  logic        buf_we, rbusy, rdone, outen;

  logic        req_ready, done, error;
  logic [7:0]  buf_dout, inbyte;
  logic [1:0]  rstart, wstart;
  logic [31:0] rsector;

  logic        s_req_ready, s_done, s_error;
  logic [7:0]  s_buf_dout, s_inbyte;
  logic [1:0]  s_rstart, s_wstart;
  logic [31:0] s_rsector;

  always #5 clk = ~clk;

  sd_sector_client #(.TIMEOUT_CYC(T_MAIN)) u_dut (
    .clk(clk), .rstn(rstn), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .req_drive(req_drive), .req_ready(req_ready), .done(done), .error(error),
    .image_mounted(image_mounted), .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we),
    .buf_dout(buf_dout), .rstart(rstart), .wstart(wstart), .rsector(rsector), .rbusy(rbusy),
    .rdone(rdone), .outen(outen), .outaddr(outaddr), .outbyte(outbyte), .inbyte(inbyte)
  );

  // Short-timeout instance shares all inputs; only watched in the timeout scenario.
  sd_sector_client #(.TIMEOUT_CYC(T_SHORT)) u_short (
    .clk(clk), .rstn(rstn), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .req_drive(req_drive), .req_ready(s_req_ready), .done(s_done), .error(s_error),
    .image_mounted(image_mounted), .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we),
    .buf_dout(s_buf_dout), .rstart(s_rstart), .wstart(s_wstart), .rsector(s_rsector),
    .rbusy(rbusy), .rdone(rdone), .outen(outen), .outaddr(outaddr), .outbyte(outbyte),
    .inbyte(s_inbyte)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected protocol outputs, set by the stimulus tasks from the transaction rules.
  logic        exp_ready, exp_done, exp_error;
  logic [1:0]  exp_rstart, exp_wstart;
  logic [31:0] exp_rsector;
  bit          cmp_en = 1'b0;

  // Buffer image: user writes, then SD read-data writes (SD wins), reads see old data.
  logic [7:0] mem [512];
  bit         mem_v [512];
  logic [7:0] exp_dout, exp_inb;
  bit         exp_dout_v = 1'b0, exp_inb_v = 1'b0;

  always @(posedge clk) begin
    exp_dout   <= mem[buf_addr];
    exp_dout_v <= mem_v[buf_addr];
    exp_inb    <= mem[outaddr];
    exp_inb_v  <= mem_v[outaddr];
    if (buf_we) begin
      mem[buf_addr]   <= buf_din;
      mem_v[buf_addr] <= 1'b1;
    end
    if (outen && (exp_rstart != 2'b00)) begin
      mem[outaddr]   <= outbyte;
      mem_v[outaddr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("done", 32'(done), 32'(exp_done));
      chk("error", 32'(error), 32'(exp_error));
      chk("rstart", 32'(rstart), 32'(exp_rstart));
      chk("wstart", 32'(wstart), 32'(exp_wstart));
      chk("rsector", rsector, exp_rsector);
      if (exp_dout_v) chk("buf_dout", 32'(buf_dout), 32'(exp_dout));
      if (exp_inb_v)  chk("inbyte", 32'(inbyte), 32'(exp_inb));
    end
  end

  int cnt_short = 0;
  bit short_err_seen = 1'b0;
  bit cnt_clr = 1'b0;

  always @(negedge clk) begin
    if (cnt_clr) begin
      cnt_short      = 0;
      short_err_seen = 1'b0;
    end else begin
      if (s_rstart != 2'b00) cnt_short++;
      if (s_done && s_error) short_err_seen = 1'b1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    req_rd = 1'b0; req_wr = 1'b0; outen = 1'b0; rdone = 1'b0; buf_we = 1'b0; rbusy = 1'b0;
  endtask

  task automatic set_reset_exp;
    exp_ready = 1'b1; exp_done = 1'b0; exp_error = 1'b0;
    exp_rstart = 2'b00; exp_wstart = 2'b00; exp_rsector = '0;
  endtask

  task automatic do_reset;
    quiet;
    rstn = 1'b0;
    cnt_clr = 1'b1;
    tick;
    set_reset_exp;
    rstn = 1'b1;
    tick;
    cnt_clr = 1'b0;
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      outen = 1'($urandom); outaddr = 9'($urandom); outbyte = 8'($urandom);
      rdone = ($urandom % 4 == 0); rbusy = 1'($urandom);
      buf_we = 1'($urandom); buf_addr = 9'($urandom); buf_din = 8'($urandom);
      tick;
    end
    quiet;
  endtask

  // One request from IDLE; the responder side is scripted and the expectations follow it.
  task automatic xfer(input bit rd, input bit wr, input bit drv, input logic [31:0] lba,
                      input int nbytes, input bit seq, input bit give_done, input int rst_at,
                      input bit noise, input bit lit_wr,
                      output bit got_done, output bit got_err,
                      output logic [3:0] seen, output logic [31:0] seen_sec);
    bit         is_rd;
    bit         fin;
    bit         emit;
    int         cyc;
    int         sent;
    logic [8:0] a;
    is_rd = rd; fin = 1'b0; cyc = 0; sent = 0; a = '0;
    seen = '0; seen_sec = '0; got_done = 1'b0; got_err = 1'b0;
    req_rd = rd; req_wr = wr; req_lba = lba; req_drive = drv;
    tick;
    req_rd = 1'b0; req_wr = 1'b0; req_lba = $urandom; req_drive = 1'($urandom);
    exp_ready = 1'b0;
    if (!image_mounted[drv]) begin
      exp_done = 1'b1; exp_error = 1'b1;
      got_done = done; got_err = error; seen = {rstart, wstart};
      tick;
      exp_done = 1'b0; exp_ready = 1'b1;
      return;
    end
    exp_error = 1'b0;
    tick;
    exp_rsector = lba;
    if (is_rd) exp_rstart[drv] = 1'b1;
    else       exp_wstart[drv] = 1'b1;
    seen = {rstart, wstart}; seen_sec = rsector;
    while (!fin) begin
      emit = 1'b0; outen = 1'b0; rdone = 1'b0; rbusy = 1'b1;
      buf_we = noise ? 1'($urandom) : 1'b0; buf_addr = 9'($urandom); buf_din = 8'($urandom);
      req_rd = noise && ($urandom % 16 == 0); req_wr = noise && ($urandom % 16 == 0);
      req_lba = $urandom;
      if (rst_at == cyc) begin
        quiet;
        rstn = 1'b0;
        tick;
        set_reset_exp;
        chk("rst_drop", 32'({rstart, wstart}), 32'd0);
        rstn = 1'b1;
        return;
      end
      if (sent < nbytes) begin
        if (seq || ($urandom % 8 != 0)) begin
          emit = 1'b1;
          a = seq ? 9'(sent) : 9'($urandom);
          outaddr = a;
          if (is_rd) begin
            outen = 1'b1;
            outbyte = seq ? (8'(sent) ^ 8'h5A) : 8'($urandom);
          end else begin
            outen = 1'($urandom);
            outbyte = 8'($urandom);
          end
          sent++;
        end
      end else if (give_done && (cyc < int'(T_MAIN) - 1)) begin
        rdone = 1'b1;
      end
      tick;
      cyc++;
      if (lit_wr && emit && (a[5:0] == 6'd0)) chk("wr_inbyte", 32'(inbyte), 32'(8'hFF - a[7:0]));
      if (rdone) begin
        fin = 1'b1;
        exp_error = is_rd && (sent != 512);
      end else if (cyc == int'(T_MAIN)) begin
        fin = 1'b1;
        exp_error = 1'b1;
      end
      if (fin) begin
        exp_rstart = 2'b00; exp_wstart = 2'b00; exp_done = 1'b1;
        got_done = done; got_err = error;
      end
    end
    quiet;
    tick;
    exp_done = 1'b0; exp_ready = 1'b1;
  endtask

  initial begin
    bit          gd, ge, rd, wr;
    logic [3:0]  sn;
    logic [31:0] ss;
    int          r, nb, ra;

    rstn = 1'b0; req_rd = 1'b0; req_wr = 1'b0; req_lba = '0; req_drive = 1'b0;
    image_mounted = 2'b11; buf_addr = '0; buf_din = '0; buf_we = 1'b0;
    rbusy = 1'b0; rdone = 1'b0; outen = 1'b0; outaddr = '0; outbyte = '0;
    tick;
    tick;
    set_reset_exp;
    cmp_en = 1'b1;
    rstn = 1'b1;
    tick;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_start", 32'({rstart, wstart}), 32'd0);

    // Full 512-byte read to drive 0.
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_1234, 512, 1'b1, 1'b1, -1, 1'b0, 1'b0, gd, ge, sn, ss);
    chk("rd_start", 32'(sn), 32'b0100);
    chk("rd_sector", ss, 32'h0000_1234);
    chk("rd_done", 32'(gd), 32'd1);
    chk("rd_err", 32'(ge), 32'd0);
    for (int i = 0; i < 512; i += 37) begin
      buf_addr = 9'(i);
      tick;
      chk("rd_buf", 32'(buf_dout), 32'(8'(i) ^ 8'h5A));
    end

    // Fill buffer, then write it to drive 1.
    for (int i = 0; i < 512; i++) begin
      buf_addr = 9'(i); buf_din = 8'hFF - 8'(i); buf_we = 1'b1;
      tick;
    end
    buf_we = 1'b0;
    xfer(1'b0, 1'b1, 1'b1, 32'h00C0_FFEE, 512, 1'b1, 1'b1, -1, 1'b0, 1'b1, gd, ge, sn, ss);
    chk("wr_start", 32'(sn), 32'b0010);
    chk("wr_done", 32'(gd), 32'd1);
    chk("wr_err", 32'(ge), 32'd0);

    // Short read.
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_0300, 300, 1'b1, 1'b1, -1, 1'b0, 1'b0, gd, ge, sn, ss);
    chk("short_done", 32'(gd), 32'd1);
    chk("short_err", 32'(ge), 32'd1);

    // Timeout: no rdone; short instance must drop after exactly 100 cycles.
    do_reset;
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_0077, 0, 1'b1, 1'b0, -1, 1'b0, 1'b0, gd, ge, sn, ss);
    chk("tmo_err", 32'(ge), 32'd1);
    chk("tmo_short_cycles", 32'(cnt_short), 32'd100);
    chk("tmo_short_err", 32'(short_err_seen), 32'd1);
    idle_noise(8);
    chk("tmo_late_ready", 32'(req_ready), 32'd1);

    // Unmounted drive.
    image_mounted = 2'b01;
    xfer(1'b1, 1'b0, 1'b1, 32'h0000_0042, 512, 1'b1, 1'b1, -1, 1'b0, 1'b0, gd, ge, sn, ss);
    chk("unm_start", 32'(sn), 32'd0);
    chk("unm_done", 32'(gd), 32'd1);
    chk("unm_err", 32'(ge), 32'd1);
    image_mounted = 2'b11;

    // Reset mid-WAIT, then simultaneous read+write pulses.
    xfer(1'b1, 1'b0, 1'b0, 32'h0000_0500, 512, 1'b1, 1'b1, 40, 1'b0, 1'b0, gd, ge, sn, ss);
    xfer(1'b1, 1'b1, 1'b0, 32'h0000_0501, 512, 1'b1, 1'b1, -1, 1'b0, 1'b0, gd, ge, sn, ss);
    chk("both_start", 32'(sn), 32'b0100);
    chk("both_err", 32'(ge), 32'd0);

    for (int k = 0; k < 20; k++) begin
      idle_noise($urandom_range(0, 5));
      image_mounted = ($urandom % 4 == 0) ? 2'($urandom) : 2'b11;
      r  = int'($urandom % 3);
      rd = (r != 1);
      wr = (r != 0);
      nb = ($urandom % 2 == 1) ? 512 : int'($urandom_range(0, 530));
      ra = ($urandom % 20 == 0) ? int'($urandom_range(0, 300)) : -1;
      xfer(rd, wr, 1'($urandom), $urandom, nb, 1'($urandom), ($urandom % 10) != 0, ra,
           1'($urandom), 1'b0, gd, ge, sn, ss);
    end
    idle_noise(4);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
